// File: rtl/writeback_stage_pkg.sv
// Shared widths, output-port state encoding and result-select helper for the writeback stage.
package writeback_stage_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_IDX_W = 3;
  localparam int OUTCNT_W  = 8;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_HOLD = 1'b1
  } out_state_e;

  function automatic logic [DATA_W-1:0] select_result(
    input logic              mem_to_reg,
    input logic [DATA_W-1:0] alu_result,
    input logic [DATA_W-1:0] mem_data
  );
    return mem_to_reg ? mem_data : alu_result;
  endfunction

endpackage

// File: rtl/out_port_ctrl.sv
// Output-port handshake: IDLE/HOLD state, held port data and acknowledged-transfer counter.
module out_port_ctrl
  import writeback_stage_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                out_ack_i,
  output logic [DATA_W-1:0]   out_port_o,
  output logic                out_valid_o,
  output logic [OUTCNT_W-1:0] out_count_o
);

  out_state_e          state_q, state_d;
  logic [DATA_W-1:0]   port_q, port_d;
  logic [OUTCNT_W-1:0] count_q, count_d;

  // Next state, next port data and counter update.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    count_d = count_q;
    case (state_q)
      OUT_IDLE: begin
        if (load_i) begin
          state_d = OUT_HOLD;
          port_d  = data_i;
        end else begin
          state_d = OUT_IDLE;
        end
      end
      OUT_HOLD: begin
        if (out_ack_i) begin
          count_d = count_q + OUTCNT_W'(1);
          if (load_i) begin
            state_d = OUT_HOLD;
            port_d  = data_i;
          end else begin
            state_d = OUT_IDLE;
          end
        end else begin
          state_d = OUT_HOLD;
        end
      end
      default: begin
        state_d = OUT_IDLE;
      end
    endcase
  end

  // State, port and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= OUT_IDLE;
      port_q  <= {DATA_W{1'b0}};
      count_q <= {OUTCNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      count_q <= count_d;
    end
  end

  assign out_port_o  = port_q;
  assign out_valid_o = (state_q == OUT_HOLD);
  assign out_count_o = count_q;

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: result mux, WB register driving the register file, and the OUT port.
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inValid,
  input  logic                 wbEn,
  input  logic                 memToReg,
  input  logic                 outEn,
  input  logic [REG_IDX_W-1:0] Rdst,
  input  logic [DATA_W-1:0]    aluResult,
  input  logic [DATA_W-1:0]    memData,
  input  logic                 outAck,
  output logic                 regWrite,
  output logic [REG_IDX_W-1:0] RdstOut,
  output logic [DATA_W-1:0]    writeData,
  output logic [DATA_W-1:0]    outPort,
  output logic                 outValid,
  output logic                 stall,
  output logic [OUTCNT_W-1:0]  outCount
);

  logic                 wb_en_q, wb_en_d;
  logic [REG_IDX_W-1:0] rdst_q, rdst_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [DATA_W-1:0]    result_s;
  logic                 accept_s;
  logic                 out_valid_s;

  assign result_s = select_result(memToReg, aluResult, memData);
  // Only an OUT entry meeting an occupied, unacknowledged port holds the pipeline.
  assign stall    = inValid & outEn & out_valid_s & ~outAck;
  assign accept_s = inValid & ~stall;

  // WB register next state: capture on accept, otherwise a bubble that keeps index/data.
  always_comb begin
    wb_en_d = 1'b0;
    rdst_d  = rdst_q;
    data_d  = data_q;
    if (accept_s) begin
      wb_en_d = wbEn;
      rdst_d  = Rdst;
      data_d  = result_s;
    end else begin
      wb_en_d = 1'b0;
    end
  end

  // WB register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_en_q <= 1'b0;
      rdst_q  <= {REG_IDX_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
    end else begin
      wb_en_q <= wb_en_d;
      rdst_q  <= rdst_d;
      data_q  <= data_d;
    end
  end

  assign regWrite  = wb_en_q;
  assign RdstOut   = rdst_q;
  assign writeData = data_q;
  assign outValid  = out_valid_s;

  out_port_ctrl u_out_port_ctrl (
    .clk_i       (clk),
    .rst_ni      (rst),
    .load_i      (accept_s & outEn),
    .data_i      (result_s),
    .out_ack_i   (outAck),
    .out_port_o  (outPort),
    .out_valid_o (out_valid_s),
    .out_count_o (outCount)
  );

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and random checks of writeback_stage against a cycle-level behavioural model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid, wbEn, memToReg, outEn, outAck;
  logic [2:0]  Rdst;
  logic [15:0] aluResult, memData;
  logic        regWrite;
  logic [2:0]  RdstOut;
  logic [15:0] writeData, outPort;
  logic        outValid, stall;
  logic [7:0]  outCount;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit       m_regwrite;
  int       m_rdst, m_wdata, m_outport, m_count;
  bit       m_outvalid;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst(rst), .inValid(inValid), .wbEn(wbEn), .memToReg(memToReg),
    .outEn(outEn), .Rdst(Rdst), .aluResult(aluResult), .memData(memData),
    .outAck(outAck), .regWrite(regWrite), .RdstOut(RdstOut), .writeData(writeData),
    .outPort(outPort), .outValid(outValid), .stall(stall), .outCount(outCount)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".regWrite"},  {15'd0, regWrite}, {15'd0, m_regwrite});
    chk({tag, ".RdstOut"},   {13'd0, RdstOut},  16'(m_rdst));
    chk({tag, ".writeData"}, writeData,         16'(m_wdata));
    chk({tag, ".outPort"},   outPort,           16'(m_outport));
    chk({tag, ".outValid"},  {15'd0, outValid}, {15'd0, m_outvalid});
    chk({tag, ".outCount"},  {8'd0, outCount},  16'(m_count));
  endtask

  // One clock: check stall against the model, apply the edge to the model, check outputs.
  task automatic cycle(input string tag);
    bit m_stall, acc;
    int sel;
    #1;
    m_stall = inValid && outEn && m_outvalid && !outAck;
    chk({tag, ".stall"}, {15'd0, stall}, {15'd0, m_stall});
    acc = inValid && !m_stall;
    sel = memToReg ? int'(memData) : int'(aluResult);
    @(posedge clk);
    if (!rst) begin
      m_regwrite = 0; m_rdst = 0; m_wdata = 0; m_outport = 0; m_outvalid = 0; m_count = 0;
    end else begin
      m_regwrite = acc && wbEn;
      if (acc) begin
        m_rdst  = int'(Rdst);
        m_wdata = sel;
      end
      if (m_outvalid && outAck) m_count = (m_count + 1) % 256;
      if (acc && outEn) begin
        m_outport  = sel;
        m_outvalid = 1;
      end else if (m_outvalid && outAck) begin
        m_outvalid = 0;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    inValid = 1'b0; wbEn = 1'b0; memToReg = 1'b0; outEn = 1'b0; outAck = 1'b0;
    Rdst = 3'd0; aluResult = 16'h0000; memData = 16'h0000;
  endtask

  task automatic entry(input logic we, input logic m2r, input logic oe, input logic [2:0] rd,
                       input logic [15:0] alu, input logic [15:0] mem);
    inValid = 1'b1; wbEn = we; memToReg = m2r; outEn = oe; Rdst = rd;
    aluResult = alu; memData = mem;
  endtask

  initial begin
    m_regwrite = 1; m_rdst = 7; m_wdata = 16'hFFFF; m_outport = 16'hFFFF; m_outvalid = 1; m_count = 255;
    idle_inputs();
    inValid = 1'b1; wbEn = 1'b1; outEn = 1'b1; outAck = 1'b1; aluResult = 16'h5555;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle("reset");
    chk("reset.outCount_const", {8'd0, outCount}, 16'h0000);
    chk("reset.outValid_const", {15'd0, outValid}, 16'h0000);
    rst = 1'b1;
    idle_inputs();
    cycle("idle0");

    // Register write, then bubble
    entry(1'b1, 1'b0, 1'b0, 3'd5, 16'h1234, 16'h9999);
    cycle("regwr");
    chk("regwr.writeData_const", writeData, 16'h1234);
    chk("regwr.RdstOut_const", {13'd0, RdstOut}, 16'd5);
    idle_inputs();
    cycle("regwr_bubble");
    chk("regwr_bubble.regWrite_const", {15'd0, regWrite}, 16'd0);

    // Memory select
    entry(1'b1, 1'b1, 1'b0, 3'd2, 16'h0001, 16'hBEEF);
    cycle("memsel");
    chk("memsel.writeData_const", writeData, 16'hBEEF);

    // Stall and recovery
    entry(1'b0, 1'b0, 1'b1, 3'd1, 16'h00AA, 16'h0000);
    outAck = 1'b0;
    cycle("out_aa");
    chk("out_aa.outPort_const", outPort, 16'h00AA);
    entry(1'b1, 1'b0, 1'b1, 3'd3, 16'h00BB, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_hold.stall_const", {15'd0, stall}, 16'd1);
      cycle("stall_hold");
      chk("stall_hold.outPort_const", outPort, 16'h00AA);
    end
    outAck = 1'b1;
    cycle("stall_release");
    chk("stall_release.outPort_const", outPort, 16'h00BB);
    chk("stall_release.outCount_const", {8'd0, outCount}, 16'd1);

    // Idle after ack, then ack while idle
    idle_inputs();
    outAck = 1'b1;
    cycle("ack_to_idle");
    chk("ack_to_idle.outValid_const", {15'd0, outValid}, 16'd0);
    cycle("ack_in_idle");
    chk("ack_in_idle.outCount_const", {8'd0, outCount}, 16'd2);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      inValid   = 1'($urandom);
      wbEn      = 1'($urandom);
      memToReg  = 1'($urandom);
      outEn     = 1'($urandom);
      outAck    = ($urandom_range(0, 3) != 0);
      Rdst      = 3'($urandom);
      aluResult = 16'($urandom);
      memData   = 16'($urandom);
      cycle("random");
    end

    // Counter wrap after 256 acknowledged transfers
    idle_inputs();
    rst = 1'b0;
    cycle("wrap_reset");
    rst = 1'b1;
    entry(1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 16'h0000);
    outAck = 1'b1;
    for (int i = 0; i < 256; i++) begin
      aluResult = 16'(i);
      cycle("wrap");
    end
    idle_inputs();
    outAck = 1'b1;
    cycle("wrap_last");
    chk("wrap.outCount_const", {8'd0, outCount}, 16'd0);

    // Reset in HOLD with outAck
    entry(1'b1, 1'b0, 1'b1, 3'd6, 16'hCAFE, 16'h0000);
    outAck = 1'b0;
    cycle("pre_rst_load");
    idle_inputs();
    outAck = 1'b1;
    rst = 1'b0;
    cycle("rst_in_hold");
    chk("rst_in_hold.outValid_const", {15'd0, outValid}, 16'd0);
    chk("rst_in_hold.outCount_const", {8'd0, outCount}, 16'd0);
    chk("rst_in_hold.outPort_const", outPort, 16'd0);
    chk("rst_in_hold.stall_const", {15'd0, stall}, 16'd0);
    rst = 1'b1;
    idle_inputs();
    cycle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
